// File: rtl/parking_pkg.sv
// Shared types and defaults for the parking gate scheduler: FSM state
// encoding, lane identifiers and the round-robin lane pick.
package parking_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_ENT_OPEN = 3'd1,
      ST_EXT_OPEN = 3'd2,
      ST_COMMIT   = 3'd3,
      ST_SETTLE   = 3'd4
   } state_t;

   typedef enum logic {
      LANE_ENT = 1'b0,
      LANE_EXT = 1'b1
   } lane_t;

   localparam int DEF_CAP        = 7;
   localparam int DEF_W          = 3;
   localparam int DEF_OPEN_TICKS = 24000;

   // With both lanes eligible the lane that did not win last time gets the barrier.
   function automatic lane_t pick_lane(input logic ent_ok, input logic ext_ok, input lane_t last);
      lane_t pick;
      if (ent_ok && ext_ok) begin
         if (last == LANE_ENT) begin
            pick = LANE_EXT;
         end else begin
            pick = LANE_ENT;
         end
      end else if (ext_ok) begin
         pick = LANE_EXT;
      end else begin
         pick = LANE_ENT;
      end
      return pick;
   endfunction

endpackage

// File: rtl/parking_gate_timer.sv
// Loadable up/down counter with clear and terminal-count flag; times how long
// a barrier has been waiting for a passage.
module gate_timer
   import parking_pkg::*;
#(
   parameter int TICKS = DEF_OPEN_TICKS,
   parameter int TW    = $clog2(TICKS)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          load,
   input  logic [TW-1:0] load_val,
   input  logic          en,
   input  logic          up,
   output logic          tc
);

   logic [TW-1:0] count_r;

   // Count register: clear has priority over load, load over counting.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_r <= {TW{1'b0}};
      end else if (clr) begin
         count_r <= {TW{1'b0}};
      end else if (load) begin
         count_r <= load_val;
      end else if (en) begin
         if (up) begin
            count_r <= count_r + TW'(1);
         end else begin
            count_r <= count_r - TW'(1);
         end
      end else begin
         count_r <= count_r;
      end
   end

   // Terminal count is the last tick when counting up, zero when counting down.
   always_comb begin
      tc = 1'b0;
      if (up) begin
         tc = (count_r == TW'(TICKS - 1));
      end else begin
         tc = (count_r == {TW{1'b0}});
      end
   end

endmodule

// File: rtl/parking_gate_scheduler.sv
// Grants the entry/exit barriers one lane at a time (round-robin when both are
// eligible) and issues exactly one counter update per completed passage.
module parking_gate_scheduler
   import parking_pkg::*;
#(
   parameter int CAP        = DEF_CAP,
   parameter int W          = DEF_W,
   parameter int OPEN_TICKS = DEF_OPEN_TICKS
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         ent_ask,
   input  logic         ext_ask,
   input  logic         ent_pass,
   input  logic         ext_pass,
   input  logic [W-1:0] occ,
   output logic         gate_ent,
   output logic         gate_ext,
   output logic         s,
   output logic         r,
   output logic         full,
   output logic         empty,
   output logic         timeout,
   output logic         err
);

   localparam int TW = $clog2(OPEN_TICKS);

   state_t state_r;
   lane_t  last_grant_r;
   lane_t  grant_lane_s;
   logic   ent_ok_s;
   logic   ext_ok_s;
   logic   bad_pass_s;
   logic   timer_en_s;
   logic   timer_clr_s;
   logic   timer_tc_s;

   gate_timer #(
      .TICKS (OPEN_TICKS),
      .TW    (TW)
   ) u_gate_timer (
      .clk      (clk),
      .rst      (rst),
      .clr      (timer_clr_s),
      .load     (1'b0),
      .load_val ({TW{1'b0}}),
      .en       (timer_en_s),
      .up       (1'b1),
      .tc       (timer_tc_s)
   );

   // Eligibility, lane choice, unauthorised-passage detection and timer control.
   always_comb begin
      ent_ok_s     = ent_ask & ~full;
      ext_ok_s     = ext_ask & ~empty;
      grant_lane_s = pick_lane(ent_ok_s, ext_ok_s, last_grant_r);
      bad_pass_s   = 1'b0;
      case (state_r)
         ST_ENT_OPEN: bad_pass_s = ext_pass;
         ST_EXT_OPEN: bad_pass_s = ent_pass;
         default:     bad_pass_s = ent_pass | ext_pass;
      endcase
      timer_en_s  = (state_r == ST_ENT_OPEN) || (state_r == ST_EXT_OPEN);
      timer_clr_s = ~timer_en_s;
   end

   // Occupancy flags are sampled every cycle; SETTLE covers their one-cycle lag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         full  <= 1'b0;
         empty <= 1'b1;
      end else begin
         full  <= (occ >= W'(CAP));
         empty <= (occ == {W{1'b0}});
      end
   end

   // Scheduler FSM with registered gate, counter and status outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r      <= ST_IDLE;
         last_grant_r <= LANE_ENT;
         gate_ent     <= 1'b0;
         gate_ext     <= 1'b0;
         s            <= 1'b0;
         r            <= 1'b0;
         timeout      <= 1'b0;
         err          <= 1'b0;
      end else begin
         s       <= 1'b0;
         r       <= 1'b0;
         timeout <= 1'b0;
         if (bad_pass_s) begin
            err <= 1'b1;
         end
         case (state_r)
            ST_IDLE: begin
               if (ent_ok_s || ext_ok_s) begin
                  last_grant_r <= grant_lane_s;
                  if (grant_lane_s == LANE_ENT) begin
                     state_r  <= ST_ENT_OPEN;
                     gate_ent <= 1'b1;
                  end else begin
                     state_r  <= ST_EXT_OPEN;
                     gate_ext <= 1'b1;
                  end
               end
            end
            // A passage beats a timeout that expires in the same cycle.
            ST_ENT_OPEN: begin
               if (ent_pass) begin
                  state_r  <= ST_COMMIT;
                  gate_ent <= 1'b0;
                  s        <= 1'b1;
               end else if (timer_tc_s) begin
                  state_r  <= ST_IDLE;
                  gate_ent <= 1'b0;
                  timeout  <= 1'b1;
               end
            end
            ST_EXT_OPEN: begin
               if (ext_pass) begin
                  state_r  <= ST_COMMIT;
                  gate_ext <= 1'b0;
                  r        <= 1'b1;
               end else if (timer_tc_s) begin
                  state_r  <= ST_IDLE;
                  gate_ext <= 1'b0;
                  timeout  <= 1'b1;
               end
            end
            ST_COMMIT: begin
               state_r <= ST_SETTLE;
            end
            ST_SETTLE: begin
               state_r <= ST_IDLE;
            end
            default: begin
               state_r  <= ST_IDLE;
               gate_ent <= 1'b0;
               gate_ext <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_parking_gate_scheduler.sv
// Self-checking bench: directed scenarios plus random traffic, every cycle
// compared against a transaction-level model of the lot controller.
module tb_parking_gate_scheduler;

   localparam int CAP = 7;
   localparam int W   = 3;
   localparam int OT  = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         ent_ask = 1'b0, ext_ask = 1'b0, ent_pass = 1'b0, ext_pass = 1'b0;
   logic [W-1:0] occ = '0;
   logic         gate_ent, gate_ext, s, r, full, empty, timeout, err;

   parking_gate_scheduler #(.CAP(CAP), .W(W), .OPEN_TICKS(OT)) dut (
      .clk(clk), .rst(rst), .ent_ask(ent_ask), .ext_ask(ext_ask),
      .ent_pass(ent_pass), .ext_pass(ext_pass), .occ(occ),
      .gate_ent(gate_ent), .gate_ext(gate_ext), .s(s), .r(r),
      .full(full), .empty(empty), .timeout(timeout), .err(err)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: which lane holds the barrier (0 none, 1 entry, 2 exit),
   // how long it has been open, and how many cycles remain before a new grant.
   int m_lane, m_age, m_cool, m_last;
   bit m_s, m_r, m_to, m_err, m_full, m_empty;
   bit ps, pr;
   int n_s, n_r, n_to, n_gent;

   task automatic check_val(input string tag, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_lane = 0; m_age = 0; m_cool = 0; m_last = 1;
      m_s = 0; m_r = 0; m_to = 0; m_err = 0; m_full = 0; m_empty = 1;
   endtask

   task automatic model_step();
      bit e_ok, x_ok;
      m_s = 0; m_r = 0; m_to = 0;
      if ((m_lane == 0 && (ent_pass || ext_pass)) || (m_lane == 1 && ext_pass) ||
          (m_lane == 2 && ent_pass))
         m_err = 1;
      if (m_lane == 1 && ent_pass) begin
         m_s = 1; m_lane = 0; m_cool = 2;
      end else if (m_lane == 2 && ext_pass) begin
         m_r = 1; m_lane = 0; m_cool = 2;
      end else if (m_lane != 0) begin
         if (m_age == OT - 1) begin m_lane = 0; m_to = 1; end
         else m_age++;
      end else if (m_cool > 0) begin
         m_cool--;
      end else begin
         e_ok = ent_ask && !m_full;
         x_ok = ext_ask && !m_empty;
         if (e_ok && x_ok) m_lane = (m_last == 1) ? 2 : 1;
         else if (e_ok) m_lane = 1;
         else if (x_ok) m_lane = 2;
         if (m_lane != 0) begin m_last = m_lane; m_age = 0; end
      end
      m_full  = (int'(occ) >= CAP);
      m_empty = (occ == 3'd0);
   endtask

   // One clock: model follows the edge, outputs compared at the falling edge,
   // then the bench-side occupancy counter applies last cycle's s/r.
   task automatic cycle();
      @(posedge clk);
      if (rst) model_reset();
      else model_step();
      @(negedge clk);
      check_val("gate_ent", int'(gate_ent), int'(m_lane == 1));
      check_val("gate_ext", int'(gate_ext), int'(m_lane == 2));
      check_val("s", int'(s), int'(m_s));
      check_val("r", int'(r), int'(m_r));
      check_val("full", int'(full), int'(m_full));
      check_val("empty", int'(empty), int'(m_empty));
      check_val("timeout", int'(timeout), int'(m_to));
      check_val("err", int'(err), int'(m_err));
      n_s += int'(s); n_r += int'(r); n_to += int'(timeout); n_gent += int'(gate_ent);
      ent_pass = 1'b0;
      ext_pass = 1'b0;
      occ = occ + 3'(ps) - 3'(pr);
      ps = m_s;
      pr = m_r;
   endtask

   task automatic do_reset();
      rst = 1'b1; ent_ask = 1'b0; ext_ask = 1'b0; ent_pass = 1'b0; ext_pass = 1'b0;
      ps = 0; pr = 0;
      model_reset();
      cycle();
      cycle();
      rst = 1'b0;
   endtask

   task automatic wait_gate(input string tag, input bit want_ext);
      int t = 0;
      while (((want_ext ? gate_ext : gate_ent) !== 1'b1) && t < 20) begin
         cycle();
         t++;
      end
      check_val(tag, int'(want_ext ? gate_ext : gate_ent), 1);
   endtask

   initial begin
      logic [3:0] order;
      int t;
      model_reset();
      ps = 0; pr = 0; n_s = 0; n_r = 0; n_to = 0; n_gent = 0;
      do_reset();
      check_val("rst_empty", int'(empty), 1);
      check_val("rst_gates", int'(gate_ent | gate_ext), 0);

      // Entry grant, passage and single increment.
      occ = 3'd0; ent_ask = 1'b1;
      cycle();
      check_val("t1_gate_rise", int'(gate_ent), 1);
      ent_ask = 1'b0;
      cycle(); cycle();
      n_s = 0;
      ent_pass = 1'b1;
      cycle();
      check_val("t1_s_pulse", int'(s), 1);
      check_val("t1_gate_closed", int'(gate_ent), 0);
      cycle();
      check_val("t1_s_once", int'(s), 0);
      cycle(); cycle();
      check_val("t1_s_count", n_s, 1);

      // Full lot refuses entry; exit still served.
      occ = 3'd7;
      cycle(); cycle();
      ent_ask = 1'b1; n_gent = 0;
      repeat (100) cycle();
      check_val("t2_no_entry", n_gent, 0);
      ext_ask = 1'b1;
      wait_gate("t2_ext_open", 1'b1);
      ent_ask = 1'b0; ext_ask = 1'b0;
      ext_pass = 1'b1;
      cycle();
      check_val("t2_r_pulse", int'(r), 1);
      cycle();
      check_val("t2_r_once", int'(r), 0);
      cycle(); cycle();

      // Contested grants alternate, exit first after reset.
      occ = 3'd3;
      do_reset();
      cycle();
      ent_ask = 1'b1; ext_ask = 1'b1; order = 4'b0; n_s = 0; n_r = 0;
      for (int k = 0; k < 4; k++) begin
         t = 0;
         while (!(gate_ent || gate_ext) && t < 20) begin cycle(); t++; end
         check_val("t4_grant_seen", int'(gate_ent | gate_ext), 1);
         order = {order[2:0], gate_ext};
         if (gate_ext) ext_pass = 1'b1;
         else ent_pass = 1'b1;
         cycle();
      end
      ent_ask = 1'b0; ext_ask = 1'b0;
      cycle(); cycle(); cycle();
      check_val("t4_order", int'(order), 10);
      check_val("t4_s_count", n_s, 2);
      check_val("t4_r_count", n_r, 2);

      // Timeout with no passage.
      ent_ask = 1'b1;
      cycle();
      ent_ask = 1'b0;
      n_gent = 1; n_to = 0; n_s = 0;
      repeat (12) cycle();
      check_val("t5_open_cycles", n_gent, OT);
      check_val("t5_timeout_cnt", n_to, 1);
      check_val("t5_no_s", n_s, 0);

      // Stray passage while idle sets sticky err.
      ext_pass = 1'b1;
      cycle();
      check_val("t6_err", int'(err), 1);
      check_val("t6_gates", int'(gate_ent | gate_ext | s | r), 0);
      repeat (3) cycle();
      check_val("t6_err_sticky", int'(err), 1);
      do_reset();
      check_val("t6_err_clear", int'(err), 0);

      // Reset during COMMIT drops the update at once.
      ent_ask = 1'b1;
      wait_gate("t7_ent_open", 1'b0);
      ent_ask = 1'b0;
      ent_pass = 1'b1;
      cycle();
      check_val("t7_commit_s", int'(s), 1);
      rst = 1'b1;
      #1;
      check_val("t7_rst_s", int'(s), 0);
      check_val("t7_rst_gates", int'(gate_ent | gate_ext), 0);
      check_val("t7_rst_empty", int'(empty), 1);
      model_reset();
      ps = 0; pr = 0;
      @(negedge clk);
      do_reset();

      // Random traffic including stray and simultaneous passes.
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 7) == 0) ent_ask = ~ent_ask;
         if ($urandom_range(0, 7) == 0) ext_ask = ~ext_ask;
         ent_pass = (m_lane == 1 && $urandom_range(0, 4) == 0) || ($urandom_range(0, 299) == 0);
         ext_pass = (m_lane == 2 && $urandom_range(0, 4) == 0) || ($urandom_range(0, 299) == 0);
         cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/parking_gate_scheduler.md
Name: parking_gate_scheduler

Overview:
- Sequences the shared occupancy counter (S = increment, R = decrement) and the two lane barriers of the parking lot.
- Receives car-waiting requests from the entry and exit lanes and grants the barrier to one lane at a time. Grants are round-robin when both lanes are eligible.
- Commits exactly one counter update per completed passage and refuses entry when the lot is full.
- Sits between the debounced lane sensors / passage FSMs and the up/down counter.

Parameters:
- CAP, 7, lot capacity; entry is refused when occ >= CAP.
- W, 3, width of the occupancy bus (CAP must be <= 2^W - 1).
- OPEN_TICKS, 24000, clk cycles a barrier stays open waiting for a passage before timeout; must be >= 2.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- rst  in  1  asynchronous, active-high reset.
- ent_ask  in  1  level: car waiting at the entry barrier.
- ext_ask  in  1  level: car waiting at the exit barrier.
- ent_pass  in  1  one-cycle pulse: car completed entry (from the entry passage FSM).
- ext_pass  in  1  one-cycle pulse: car completed exit.
- occ  in  W  current count from the up/down counter.
- gate_ent  out  1  entry barrier open.
- gate_ext  out  1  exit barrier open.
- s  out  1  one-cycle increment pulse to the counter.
- r  out  1  one-cycle decrement pulse to the counter.
- full  out  1  registered, occ >= CAP.
- empty  out  1  registered, occ == 0.
- timeout  out  1  one-cycle pulse: a barrier closed without a passage.
- err  out  1  sticky: unauthorised passage seen; cleared only by rst.

Behaviour:
- Reset, asynchronous: state = IDLE.
  - gate_ent, gate_ext, s, r, timeout, err all 0.
  - full = 0, empty = 1, timer = 0.
  - last_grant = ENT, so the first contested grant goes to exit (frees space).
- full and empty are registered from occ every cycle, so they have 1-cycle latency.
- Eligibility:
  - ent_ok = ent_ask & ~full
  - ext_ok = ext_ask & ~empty
- States: IDLE, ENT_OPEN, EXT_OPEN, COMMIT, SETTLE.
- IDLE:
  - Both eligible: grant the lane not equal to last_grant.
  - Only one eligible: grant it.
  - Neither eligible: stay in IDLE.
  - On a grant: go to ENT_OPEN or EXT_OPEN, update last_grant, clear timer. The gate output rises on the cycle after the grant decision.
- ENT_OPEN:
  - gate_ent = 1; timer increments each cycle.
  - ent_pass = 1: go to COMMIT with dir = IN. The gate closes in the same edge.
  - Else, when timer == OPEN_TICKS-1: go to IDLE and pulse timeout for 1 cycle. No counter update.
  - Dropping ent_ask does not close the barrier; only a passage or the timeout does.
- EXT_OPEN: mirror of ENT_OPEN, using ext_pass and dir = OUT.
- COMMIT: exactly one cycle.
  - dir = IN: s = 1.
  - dir = OUT: r = 1.
  - Next state is SETTLE.
- SETTLE: exactly one cycle, waits for the counter and the registered full/empty to update. Then go to IDLE.
- Cycle count, pass pulse to the next possible grant: 3 cycles (COMMIT, SETTLE, IDLE decision).
- s and r are never asserted together and never outside COMMIT.
- Unauthorised passage sets err:
  - any pass pulse in IDLE, COMMIT or SETTLE;
  - ext_pass in ENT_OPEN, or ent_pass in EXT_OPEN.
  - The state is unaffected.
- ent_pass and ext_pass together in ENT_OPEN: commit IN and set err. Mirror rule in EXT_OPEN.
- Pass arriving in the same cycle the timer expires: the pass wins and no timeout pulse is generated.
- The block trusts the counter not to wrap: the full/empty gating guarantees no s at occ = CAP and no r at occ = 0.
- rst asserted mid-operation: gates close immediately (asynchronously). A pending COMMIT is dropped and no s/r pulse is emitted.

Decomposition:
- Shared package parking_pkg holds:
  - the state encoding (IDLE/ENT_OPEN/EXT_OPEN/COMMIT/SETTLE);
  - the lane identifiers ENT/EXT;
  - the default CAP and OPEN_TICKS constants.
- One natural sub-module: gate_timer. It is a loadable down/up counter with a clear input and a terminal-count flag, width $clog2(OPEN_TICKS).

Test Plan:
- Reset, then occ = 0 and ent_ask = 1: grant. gate_ent = 1 from cycle 2; ent_pass at cycle 10 gives s = 1 at cycle 11 only, then gate_ent = 0.
- occ = 7 (CAP) with ent_ask = 1 and ext_ask = 0: gate_ent stays 0 for 100 cycles. Raise ext_ask: gate_ext opens; ext_pass gives r = 1 for one cycle.
- occ = 3 and both asks held for 4 passages: the grant order is EXT, ENT, EXT, ENT, with s/r pulses matching.
- Set OPEN_TICKS = 8 and ent_ask with no pass: gate_ent high for exactly 8 cycles, then a timeout pulse of 1 cycle; no s.
- ext_pass pulse while in IDLE: err = 1 and stays 1. State, gates, s and r unchanged. rst clears err.
- rst asserted during COMMIT: s stays 0, all gates 0 in the same cycle, empty = 1.
